conv_pool_stage: RTL and testbench
==================================

CONV_POOL_STAGE -- requirements
Module: conv_pool_stage

Interface
REQ-001 The block SHALL have parameter width, default 32, meaning the width of the signed conv result word.
REQ-002 The block SHALL have parameter img_size, default 64, meaning the conv output map edge length in words; it SHALL be even and at least 2.
REQ-003 The block SHALL have parameter fifo_depth, default 4, meaning the number of output FIFO entries; it SHALL be a power of 2.
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-006 Port frame_start  input  1  is a one-cycle pulse that begins a new frame.
REQ-007 Port result  input  width  is the signed conv output word.
REQ-008 Port result_en  input  1  qualifies result; it has no backpressure.
REQ-009 Port pool_data  output  width  is the pooled word at the FIFO head.
REQ-010 Port pool_valid  output  1  indicates that pool_data is valid.
REQ-011 Port pool_ready  input  1  is the consumer accept signal.
REQ-012 Port frame_done  output  1  is a one-cycle pulse after the last pooled word of the frame is pushed.
REQ-013 Port overflow  output  1  is a sticky flag set when a pooled word is dropped.

Function
REQ-014 The block SHALL compute a 2x2 stride-2 max-pool over a row-major img_size x img_size stream, using signed comparison.
REQ-015 The FSM SHALL have states IDLE, EVEN and ODD.
- IDLE -> EVEN on frame_start.
- EVEN -> ODD after img_size words.
- ODD -> EVEN after img_size words, or ODD -> IDLE after the last row.
REQ-016 While in IDLE, result_en SHALL be ignored.
REQ-017 In EVEN, the max of columns 2k and 2k+1 SHALL be stored in line_buf[k], where line_buf has img_size/2 entries of width bits.
REQ-018 In ODD, the column-pair max SHALL be compared with line_buf[k], and the result SHALL be pushed into the FIFO on the edge that accepts column 2k+1.
REQ-019 The pushed word SHALL appear at pool_data with pool_valid high on the next cycle when the FIFO was empty (latency 1 cycle).
REQ-020 A FIFO pop SHALL occur on any edge where pool_valid && pool_ready; pool_data SHALL hold stable while pool_valid && !pool_ready.
REQ-021 When a push occurs with the FIFO full and no pop, the word SHALL be dropped and overflow set; a simultaneous push and pop when full SHALL succeed.
REQ-022 frame_done SHALL pulse on the cycle after the push of pooled word (img_size/2)^2, coinciding with the ODD->IDLE transition.
REQ-023 A frame_start received in EVEN or ODD SHALL restart the counters at row 0 and column 0, flush the FIFO, and leave overflow unchanged.
REQ-024 A frame_start coinciding with result_en SHALL take priority; that word SHALL be discarded.
REQ-025 The column and row counters SHALL be $clog2(img_size) bits wide and wrap at img_size-1.

Reset
REQ-026 Asserting rst SHALL immediately put the FSM in IDLE and clear the counters, the FIFO pointers and count, and line_buf.
REQ-027 During and after rst: pool_valid=0, pool_data=0, frame_done=0, overflow=0.
REQ-028 Asserting rst mid-frame SHALL abandon the frame; no frame_done SHALL be issued.
REQ-029 Reset deassertion SHALL be synchronised externally; the block SHALL accept input from the first edge after deassertion.

Configuration
REQ-030 With macro CONV_POOL_RELU_EN defined, each result SHALL be clamped to max(result, 0) before pooling.
REQ-031 With CONV_POOL_RELU_EN undefined, raw signed results SHALL be pooled, and no clamp logic SHALL exist.

Structure
REQ-032 The shared package conv_pkg SHALL hold the WORD_LEN=32 constant and the pool_state_t enum (IDLE, EVEN, ODD).
REQ-033 The output FIFO SHALL be a sub-module named conv_pool_fifo (parameters width and fifo_depth; push/pop/full/empty).
REQ-034 Line buffer, counters and FSM SHALL remain in conv_pool_stage.

Verification (img_size=4, fifo_depth=4)
REQ-035 frame_start, then rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} with pool_ready=1 -> outputs 6,8,14,16, then a frame_done pulse.
REQ-036 All words set to -5, with CONV_POOL_RELU_EN undefined -> four outputs of -5; with it defined -> four outputs of 0.
REQ-037 pool_ready=0 over two frames (8 pooled words) -> the first 4 words are held in order, overflow=1, and pool_data is stable.
REQ-038 rst asserted after 6 input words, then a full frame -> no frame_done before the rst, and correct 4 outputs after it.
REQ-039 frame_start reissued after row 1 -> counters restart, and only the second frame's 4 results are emitted.
REQ-040 FIFO full with push and pop on the same edge -> no drop, overflow stays 0, and order is preserved.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the conv/pool datapath: default word length and the
// row-phase state encoding used by the pooling stage.
package conv_pkg;

   localparam int WORD_LEN = 32;

   typedef enum logic [1:0] {
      IDLE,
      EVEN,
      ODD
   } pool_state_t;

endpackage

// File: rtl/conv_pool_fifo.sv
// Output FIFO for pooled words. The head word is shown combinationally and
// forced to zero while empty; flush drops all entries in one cycle.
module conv_pool_fifo #(
   parameter int width      = 32,
   parameter int fifo_depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int cnt_w = ptr_w + 1;

   logic [width-1:0] mem [fifo_depth];
   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic [cnt_w-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == cnt_w'(fifo_depth));
   assign do_pop   = pop && !empty;
   // A push into a full FIFO still lands when the head leaves on the same edge.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ptr_w'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ptr_w'(1);
         end
         count <= count + cnt_w'(do_push) - cnt_w'(do_pop);
      end
   end

endmodule

// File: rtl/conv_pool_stage.sv
// 2x2 stride-2 signed max-pool over a row-major conv output stream, with an
// output FIFO. Define CONV_POOL_RELU_EN to clamp negative inputs to zero first.
module conv_pool_stage
   import conv_pkg::*;
#(
   parameter int width      = WORD_LEN,
   parameter int img_size   = 64,
   parameter int fifo_depth = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start,
   input  logic signed [width-1:0] result,
   input  logic                    result_en,
   output logic        [width-1:0] pool_data,
   output logic                    pool_valid,
   input  logic                    pool_ready,
   output logic                    frame_done,
   output logic                    overflow
);

   localparam int cnt_w = $clog2(img_size);
   localparam int half  = img_size / 2;
   localparam int idx_w = (half > 1) ? $clog2(half) : 1;

   pool_state_t             state;
   pool_state_t             state_nxt;
   logic [cnt_w-1:0]        col;
   logic [cnt_w-1:0]        row;
   logic [idx_w-1:0]        pair_idx;
   logic signed [width-1:0] word;
   logic signed [width-1:0] hold;
   logic signed [width-1:0] pair_max;
   logic signed [width-1:0] pool_max;
   logic signed [width-1:0] line_buf [half];
   logic                    last_col;
   logic                    last_row;
   logic                    accept;
   logic                    push;
   logic                    pop;
   logic                    flush;
   logic                    fifo_full;
   logic                    fifo_empty;

`ifdef CONV_POOL_RELU_EN
   assign word = result[width-1] ? '0 : result;
`else
   assign word = result;
`endif

   // hold keeps the even column of the current pair until its partner arrives.
   assign pair_idx = idx_w'(col >> 1);
   assign pair_max = (word > hold) ? word : hold;
   assign pool_max = (pair_max > line_buf[pair_idx]) ? pair_max : line_buf[pair_idx];
   assign last_col = (col == cnt_w'(img_size - 1));
   assign last_row = (row == cnt_w'(img_size - 1));
   assign pool_valid = !fifo_empty;
   assign pop        = pool_valid && pool_ready;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      push      = 1'b0;
      flush     = 1'b0;
      if (frame_start) begin
         state_nxt = EVEN;
         flush     = (state != IDLE);
      end else if (state != IDLE && result_en) begin
         accept = 1'b1;
         push   = (state == ODD) && col[0];
         if (last_col) begin
            if (state == EVEN) begin
               state_nxt = ODD;
            end else if (last_row) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = EVEN;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         hold       <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         for (int i = 0; i < half; i++) begin
            line_buf[i] <= '0;
         end
      end else begin
         state      <= state_nxt;
         frame_done <= accept && (state == ODD) && last_col && last_row;
         overflow   <= overflow | (push && fifo_full && !pop);
         if (frame_start) begin
            col <= '0;
            row <= '0;
         end else if (accept) begin
            col <= last_col ? '0 : col + cnt_w'(1);
            if (last_col) begin
               row <= last_row ? '0 : row + cnt_w'(1);
            end
            if (!col[0]) begin
               hold <= word;
            end else if (state == EVEN) begin
               line_buf[pair_idx] <= pair_max;
            end
         end
      end
   end

   conv_pool_fifo #(
      .width      (width),
      .fifo_depth (fifo_depth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (pool_max),
      .pop       (pop),
      .pop_data  (pool_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_conv_pool_stage.sv
// Bench for conv_pool_stage at img_size=4, fifo_depth=4: random and directed
// frames against a 2x2 max-pool model, with a queue-based output scoreboard.
module tb_conv_pool_stage;

   localparam int W   = 32;
   localparam int IMG = 4;
   localparam int FD  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic [W-1:0]  result = '0;
   logic          result_en = 1'b0;
   logic [W-1:0]  pool_data;
   logic          pool_valid;
   logic          pool_ready;
   logic          frame_done;
   logic          overflow;

   logic          rand_mode = 1'b0;
   logic          rand_ready = 1'b1;
   logic          ready_fixed = 1'b1;
   int            low_run = 0;

   logic [W-1:0]  exp_q[$];
   int            total = 0;
   int            bad = 0;
   int            fd_seen = 0;
   int            fd0;
   logic          stall_prev = 1'b0;
   logic [W-1:0]  stall_data = '0;
   int            frame_w[IMG*IMG];

   assign pool_ready = rand_mode ? rand_ready : ready_fixed;

   conv_pool_stage #(
      .width      (W),
      .img_size   (IMG),
      .fifo_depth (FD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .result      (result),
      .result_en   (result_en),
      .pool_data   (pool_data),
      .pool_valid  (pool_valid),
      .pool_ready  (pool_ready),
      .frame_done  (frame_done),
      .overflow    (overflow)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // random consumer: never low for more than two cycles running
   always @(posedge clk) begin
      #1;
      if (low_run >= 2) begin
         rand_ready = 1'b1;
         low_run    = 0;
      end else begin
         rand_ready = ($urandom_range(0, 3) != 0);
         low_run    = rand_ready ? 0 : low_run + 1;
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, $signed(act), $signed(exp));
      end
   endtask

   function automatic int model_word(input int v);
`ifdef CONV_POOL_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // expected pooled words of frame_w, in emission order; only the first keep are queued
   task automatic push_expected(input int keep);
      int n = 0;
      for (int pr = 0; pr < IMG / 2; pr++) begin
         for (int pc = 0; pc < IMG / 2; pc++) begin
            int m = model_word(frame_w[(2*pr)*IMG + 2*pc]);
            m = max2(m, model_word(frame_w[(2*pr)*IMG + 2*pc + 1]));
            m = max2(m, model_word(frame_w[(2*pr+1)*IMG + 2*pc]));
            m = max2(m, model_word(frame_w[(2*pr+1)*IMG + 2*pc + 1]));
            if (n < keep) exp_q.push_back(W'(m));
            n++;
         end
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < IMG*IMG; i++) begin
         if ($urandom_range(0, 1) == 1) frame_w[i] = int'($urandom_range(0, 40)) - 20;
         else frame_w[i] = int'($urandom);
      end
   endtask

   // driver: optional frame_start pulse, then n words of frame_w
   task automatic send_words(input int n, input bit do_start, input bit gaps, input int ready_at);
      if (do_start) begin
         frame_start = 1'b1;
         @(posedge clk); #1;
         frame_start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         if (i == ready_at) ready_fixed = 1'b1;
         result    = frame_w[i];
         result_en = 1'b1;
         @(posedge clk); #1;
         result_en = 1'b0;
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, W'(exp_q.size()), '0);
      repeat (3) begin
         @(posedge clk); #1;
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (frame_done) fd_seen++;
         if (stall_prev && pool_valid) check("hold_stable", pool_data, stall_data);
         if (pool_valid && pool_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'd1, 32'd0);
            end else begin
               check("pool_data", pool_data, exp_q.pop_front());
            end
         end
         stall_prev = pool_valid && !pool_ready;
         stall_data = pool_data;
      end
   end

   initial begin
      // reset state
      #12;
      check("rst_pool_valid", W'(pool_valid), '0);
      check("rst_pool_data", pool_data, '0);
      check("rst_frame_done", W'(frame_done), '0);
      check("rst_overflow", W'(overflow), '0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_pool_valid", W'(pool_valid), '0);

      // directed 1..16 frame
      for (int i = 0; i < IMG*IMG; i++) frame_w[i] = i + 1;
      fd0 = fd_seen;
      push_expected(4);
      send_words(IMG*IMG, 1'b1, 1'b0, -1);
      check("frame_done_pulse", W'(frame_done), 32'd1);
      @(posedge clk); #1;
      check("frame_done_clear", W'(frame_done), '0);
      wait_drain("drain_directed");
      check("frame_done_count_directed", W'(fd_seen - fd0), 32'd1);
      check("overflow_directed", W'(overflow), '0);

      // all -5 frame
      for (int i = 0; i < IMG*IMG; i++) frame_w[i] = -5;
      push_expected(4);
      send_words(IMG*IMG, 1'b1, 1'b0, -1);
      wait_drain("drain_minus5");

      // random frames, random gaps and backpressure
      rand_mode = 1'b1;
      for (int f = 0; f < 8; f++) begin
         fill_random();
         fd0 = fd_seen;
         push_expected(4);
         send_words(IMG*IMG, 1'b1, 1'b1, -1);
         wait_drain("drain_random");
         check("frame_done_count_random", W'(fd_seen - fd0), 32'd1);
      end
      rand_mode   = 1'b0;
      ready_fixed = 1'b1;

      // restart after row 0; restart pulse coincides with a bogus word
      fill_random();
      fd0 = fd_seen;
      send_words(IMG, 1'b1, 1'b0, -1);
      for (int i = 0; i < IMG*IMG; i++) frame_w[i] = int'($urandom_range(0, 200)) - 100;
      push_expected(4);
      frame_start = 1'b1;
      result      = W'(1000);
      result_en   = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      result_en   = 1'b0;
      send_words(IMG*IMG, 1'b0, 1'b0, -1);
      wait_drain("drain_restart");
      check("frame_done_count_restart", W'(fd_seen - fd0), 32'd1);

      // full FIFO with push and pop on the same edge
      ready_fixed = 1'b0;
      fill_random();
      push_expected(4);
      send_words(IMG*IMG, 1'b1, 1'b0, -1);
      check("full_valid", W'(pool_valid), 32'd1);
      fill_random();
      push_expected(4);
      send_words(IMG*IMG, 1'b1, 1'b0, 5);
      check("overflow_push_pop_full", W'(overflow), '0);
      wait_drain("drain_push_pop_full");

      // two frames without a consumer: last four words dropped
      ready_fixed = 1'b0;
      fill_random();
      push_expected(4);
      send_words(IMG*IMG, 1'b1, 1'b1, -1);
      fill_random();
      push_expected(0);
      send_words(IMG*IMG, 1'b1, 1'b1, -1);
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("overflow_set", W'(overflow), 32'd1);
      check("stall_head", pool_data, exp_q[0]);
      ready_fixed = 1'b1;
      wait_drain("drain_overflow");
      check("overflow_sticky", W'(overflow), 32'd1);

      // reset mid-frame after six words
      ready_fixed = 1'b0;
      fill_random();
      fd0 = fd_seen;
      send_words(6, 1'b1, 1'b0, -1);
      rst = 1'b1;
      #1;
      check("midrst_pool_valid", W'(pool_valid), '0);
      check("midrst_pool_data", pool_data, '0);
      check("midrst_overflow", W'(overflow), '0);
      check("midrst_frame_done", W'(frame_done), '0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_no_frame_done", W'(fd_seen - fd0), '0);
      ready_fixed = 1'b1;
      fill_random();
      push_expected(4);
      send_words(IMG*IMG, 1'b1, 1'b0, -1);
      wait_drain("drain_after_rst");
      check("frame_done_count_after_rst", W'(fd_seen - fd0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
